// File: rtl/fpu_pkg.sv
// Shared FPU definitions: handshake state encoding and single-precision constants
// used by the adder, the issue logic and the requester.
package fpu_pkg;

   localparam int FP32_W = 32;
   localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEND_A = 3'd1,
      ST_SEND_B = 3'd2,
      ST_WAIT_Z = 3'd3,
      ST_RESP   = 3'd4
   } fpu_hs_state_e;

endpackage

// File: rtl/fpu_hs_timer.sv
// Clear-able cycle counter that flags the last permitted cycle of a handshake wait.
module fpu_hs_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Saturates at LAST so a long stall can never wrap back to a non-expired value.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/fpu_add_requester.sv
// Initiator-side handshake engine: sends A then B to the FPU adder, collects the sum
// and returns it upstream, substituting a quiet NaN with an error flag on timeout.
module fpu_add_requester
   import fpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [FP32_W-1:0] req_a,
   input  logic [FP32_W-1:0] req_b,
   output logic [FP32_W-1:0] input_a,
   output logic [FP32_W-1:0] input_b,
   output logic              input_a_stb,
   output logic              input_b_stb,
   input  logic              input_a_ack,
   input  logic              input_b_ack,
   input  logic [FP32_W-1:0] output_z,
   input  logic              output_z_stb,
   output logic              output_z_ack,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [FP32_W-1:0] rsp_z,
   output logic              rsp_err,
   output logic [CNT_W-1:0]  done_count
);

   fpu_hs_state_e     state_q;
   logic [FP32_W-1:0] a_q;
   logic [FP32_W-1:0] b_q;
   logic [FP32_W-1:0] rsp_z_q;
   logic              rsp_err_q;
   logic [CNT_W-1:0]  done_count_q;

   logic accept;
   logic aXfer;
   logic bXfer;
   logic timerEnable;
   logic expire;

   assign accept      = (state_q == ST_IDLE) && req_valid;
   assign aXfer       = (state_q == ST_SEND_A) && input_a_ack;
   assign bXfer       = (state_q == ST_SEND_B) && input_b_ack;
   assign timerEnable = (state_q == ST_SEND_A) || (state_q == ST_SEND_B) ||
                        (state_q == ST_WAIT_Z);

   fpu_hs_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear_i (accept || aXfer || bXfer),
      .enable_i(timerEnable),
      .expire_o(expire)
   );

   // A transfer is tested before expiry in every wait state, so a tie never errors.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         rsp_z_q      <= '0;
         rsp_err_q    <= 1'b0;
         done_count_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  a_q     <= req_a;
                  b_q     <= req_b;
                  state_q <= ST_SEND_A;
               end
            end
            ST_SEND_A: begin
               if (input_a_ack) begin
                  state_q <= ST_SEND_B;
               end else if (expire) begin
                  rsp_z_q   <= FP32_QNAN;
                  rsp_err_q <= 1'b1;
                  state_q   <= ST_RESP;
               end
            end
            ST_SEND_B: begin
               if (input_b_ack) begin
                  state_q <= ST_WAIT_Z;
               end else if (expire) begin
                  rsp_z_q   <= FP32_QNAN;
                  rsp_err_q <= 1'b1;
                  state_q   <= ST_RESP;
               end
            end
            ST_WAIT_Z: begin
               if (output_z_stb) begin
                  rsp_z_q   <= output_z;
                  rsp_err_q <= 1'b0;
                  state_q   <= ST_RESP;
               end else if (expire) begin
                  rsp_z_q   <= FP32_QNAN;
                  rsp_err_q <= 1'b1;
                  state_q   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  if (!rsp_err_q) begin
                     done_count_q <= done_count_q + 1'b1;
                  end
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // req_ready is gated by rst so it reads 0 throughout reset even though IDLE is the reset state.
   assign req_ready    = rst && (state_q == ST_IDLE);
   assign input_a      = a_q;
   assign input_b      = b_q;
   assign input_a_stb  = (state_q == ST_SEND_A);
   assign input_b_stb  = (state_q == ST_SEND_B);
   assign output_z_ack = (state_q == ST_WAIT_Z);
   assign rsp_valid    = (state_q == ST_RESP);
   assign rsp_z        = rsp_z_q;
   assign rsp_err      = rsp_err_q;
   assign done_count   = done_count_q;

endmodule

// File: tb/tb_fpu_add_requester.sv
// Directed self-checking bench for fpu_add_requester with a short timeout so
// expiry and tie cases are reachable in a few cycles.
module tb_fpu_add_requester;

   localparam int TO    = 8;
   localparam int CNT_W = 16;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [31:0]       req_a;
   logic [31:0]       req_b;
   logic [31:0]       input_a;
   logic [31:0]       input_b;
   logic              input_a_stb;
   logic              input_b_stb;
   logic              input_a_ack;
   logic              input_b_ack;
   logic [31:0]       output_z;
   logic              output_z_stb;
   logic              output_z_ack;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_z;
   logic              rsp_err;
   logic [CNT_W-1:0]  done_count;

   int checks;
   int errors;

   fpu_add_requester #(
      .TIMEOUT_CYCLES(TO),
      .CNT_W         (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .input_a     (input_a),
      .input_b     (input_b),
      .input_a_stb (input_a_stb),
      .input_b_stb (input_b_stb),
      .input_a_ack (input_a_ack),
      .input_b_ack (input_b_ack),
      .output_z    (output_z),
      .output_z_stb(output_z_stb),
      .output_z_ack(output_z_ack),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_z       (rsp_z),
      .rsp_err     (rsp_err),
      .done_count  (done_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it before sampling/driving.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b0;
      req_valid    = 1'b0;
      req_a        = '0;
      req_b        = '0;
      input_a_ack  = 1'b0;
      input_b_ack  = 1'b0;
      output_z     = '0;
      output_z_stb = 1'b0;
      rsp_ready    = 1'b0;

      // Reset state
      #1;
      checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("rst_a_stb", {31'd0, input_a_stb}, 32'd0);
      checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("rst_rsp_z", rsp_z, 32'd0);
      checkOutput("rst_input_a", input_a, 32'd0);
      checkOutput("rst_done", {16'd0, done_count}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rel_req_ready", {31'd0, req_ready}, 32'd1);

      // Basic add 15.75 + 7.25 = 23.0 with an always-ready adder
      input_a_ack  = 1'b1;
      input_b_ack  = 1'b1;
      output_z_stb = 1'b1;
      output_z     = 32'h41B8_0000;
      req_a        = 32'h417C_0000;
      req_b        = 32'h40E8_0000;
      req_valid    = 1'b1;
      applyStimulus();
      req_valid = 1'b0;
      checkOutput("basic_a_stb", {31'd0, input_a_stb}, 32'd1);
      checkOutput("basic_b_stb_early", {31'd0, input_b_stb}, 32'd0);
      checkOutput("basic_input_a", input_a, 32'h417C_0000);
      checkOutput("basic_req_ready", {31'd0, req_ready}, 32'd0);
      applyStimulus();
      checkOutput("basic_b_stb", {31'd0, input_b_stb}, 32'd1);
      checkOutput("basic_a_stb_off", {31'd0, input_a_stb}, 32'd0);
      checkOutput("basic_input_b", input_b, 32'h40E8_0000);
      applyStimulus();
      checkOutput("basic_z_ack", {31'd0, output_z_ack}, 32'd1);
      checkOutput("basic_no_rsp", {31'd0, rsp_valid}, 32'd0);
      applyStimulus();
      checkOutput("basic_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("basic_rsp_z", rsp_z, 32'h41B8_0000);
      checkOutput("basic_rsp_err", {31'd0, rsp_err}, 32'd0);
      rsp_ready = 1'b1;
      applyStimulus();
      rsp_ready = 1'b0;
      checkOutput("basic_done", {16'd0, done_count}, 32'd1);
      checkOutput("basic_idle_ready", {31'd0, req_ready}, 32'd1);

      // Ack delay: A held off 5 cycles, B held off 3 cycles; 1.0 + 2.0 = 3.0
      input_a_ack  = 1'b0;
      input_b_ack  = 1'b0;
      output_z_stb = 1'b0;
      req_a        = 32'h3F80_0000;
      req_b        = 32'h4000_0000;
      req_valid    = 1'b1;
      applyStimulus();
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("dly_a_stb", {31'd0, input_a_stb}, 32'd1);
         checkOutput("dly_input_a", input_a, 32'h3F80_0000);
         applyStimulus();
      end
      checkOutput("dly_a_still", {31'd0, input_a_stb}, 32'd1);
      input_a_ack = 1'b1;
      applyStimulus();
      input_a_ack = 1'b0;
      checkOutput("dly_a_single", {31'd0, input_a_stb}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("dly_b_stb", {31'd0, input_b_stb}, 32'd1);
         checkOutput("dly_input_b", input_b, 32'h4000_0000);
         applyStimulus();
      end
      input_b_ack = 1'b1;
      applyStimulus();
      input_b_ack = 1'b0;
      checkOutput("dly_b_single", {31'd0, input_b_stb}, 32'd0);
      checkOutput("dly_z_ack", {31'd0, output_z_ack}, 32'd1);
      output_z_stb = 1'b1;
      output_z     = 32'h4040_0000;
      applyStimulus();
      output_z_stb = 1'b0;
      checkOutput("dly_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("dly_rsp_z", rsp_z, 32'h4040_0000);

      // Backpressure: rsp_ready low 10 cycles while a new request waits (5.0, 6.0)
      req_a     = 32'h40A0_0000;
      req_b     = 32'h40C0_0000;
      req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         checkOutput("bp_rsp_z", rsp_z, 32'h4040_0000);
         checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
         applyStimulus();
      end
      checkOutput("bp_done_hold", {16'd0, done_count}, 32'd1);
      rsp_ready = 1'b1;
      applyStimulus();
      rsp_ready = 1'b0;
      checkOutput("bp_done", {16'd0, done_count}, 32'd2);
      checkOutput("bp_ready_after", {31'd0, req_ready}, 32'd1);
      checkOutput("bp_not_taken", input_a, 32'h3F80_0000);
      applyStimulus();
      req_valid = 1'b0;
      checkOutput("bp_accepted", input_a, 32'h40A0_0000);
      checkOutput("bp_send_a", {31'd0, input_a_stb}, 32'd1);

      // Timeout in WAIT_Z: adder never returns a sum
      input_a_ack = 1'b1;
      input_b_ack = 1'b1;
      applyStimulus();
      applyStimulus();
      input_a_ack = 1'b0;
      input_b_ack = 1'b0;
      for (int i = 0; i < TO; i++) begin
         checkOutput("to_wait_z", {31'd0, output_z_ack}, 32'd1);
         applyStimulus();
      end
      checkOutput("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("to_rsp_z", rsp_z, 32'h7FC0_0000);
      checkOutput("to_rsp_err", {31'd0, rsp_err}, 32'd1);
      rsp_ready = 1'b1;
      applyStimulus();
      rsp_ready = 1'b0;
      checkOutput("to_done_same", {16'd0, done_count}, 32'd2);

      // Tie: input_b_ack arrives on the expiry edge of SEND_B
      req_a       = 32'h3F80_0000;
      req_b       = 32'h3F80_0000;
      req_valid   = 1'b1;
      input_a_ack = 1'b1;
      applyStimulus();
      req_valid = 1'b0;
      applyStimulus();
      input_a_ack = 1'b0;
      for (int i = 0; i < TO - 1; i++) begin
         checkOutput("tie_b_stb", {31'd0, input_b_stb}, 32'd1);
         applyStimulus();
      end
      checkOutput("tie_last_b", {31'd0, input_b_stb}, 32'd1);
      input_b_ack = 1'b1;
      applyStimulus();
      input_b_ack = 1'b0;
      checkOutput("tie_wait_z", {31'd0, output_z_ack}, 32'd1);
      checkOutput("tie_no_rsp", {31'd0, rsp_valid}, 32'd0);
      output_z_stb = 1'b1;
      output_z     = 32'h4000_0000;
      applyStimulus();
      output_z_stb = 1'b0;
      checkOutput("tie_rsp_z", rsp_z, 32'h4000_0000);
      checkOutput("tie_rsp_err", {31'd0, rsp_err}, 32'd0);
      rsp_ready = 1'b1;
      applyStimulus();
      rsp_ready = 1'b0;
      checkOutput("tie_done", {16'd0, done_count}, 32'd3);

      // Reset in SEND_B drops everything asynchronously
      req_a       = 32'h4120_0000;
      req_b       = 32'h41A0_0000;
      req_valid   = 1'b1;
      input_a_ack = 1'b1;
      applyStimulus();
      req_valid = 1'b0;
      applyStimulus();
      input_a_ack = 1'b0;
      checkOutput("mr_in_send_b", {31'd0, input_b_stb}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("mr_b_stb", {31'd0, input_b_stb}, 32'd0);
      checkOutput("mr_a_stb", {31'd0, input_a_stb}, 32'd0);
      checkOutput("mr_z_ack", {31'd0, output_z_ack}, 32'd0);
      checkOutput("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("mr_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("mr_input_b", input_b, 32'd0);
      checkOutput("mr_done", {16'd0, done_count}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("mr_rel_ready", {31'd0, req_ready}, 32'd1);

      // Post-reset add 10.0 + 20.0 = 30.0
      input_a_ack  = 1'b1;
      input_b_ack  = 1'b1;
      output_z_stb = 1'b1;
      output_z     = 32'h41F0_0000;
      req_valid    = 1'b1;
      applyStimulus();
      req_valid = 1'b0;
      applyStimulus();
      applyStimulus();
      applyStimulus();
      checkOutput("post_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("post_rsp_z", rsp_z, 32'h41F0_0000);
      checkOutput("post_rsp_err", {31'd0, rsp_err}, 32'd0);
      rsp_ready = 1'b1;
      applyStimulus();
      rsp_ready = 1'b0;
      checkOutput("post_done", {16'd0, done_count}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_add_requester.md
# fpu_add_requester

Initiator-side handshake engine for the FPU adder. Accepts an operand pair from an upstream valid/ready port and sends operand A, then operand B, to the adder over its strobe/acknowledge interface. It then accepts the sum with its own acknowledge and returns the result upstream. It sits between the FPU issue logic and the adder, and a timeout prevents a stalled adder from hanging the issuing pipeline.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles spent waiting in any one handshake state before the request is aborted; must be ≥2.
- CNT_W, 16: width of the completed-operation counter.
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  upstream operand pair valid.
- req_ready  out  1  block can accept a pair.
- req_a, req_b  in  32  IEEE-754 single-precision operands.
- input_a, input_b  out  32  operands presented to the adder.
- input_a_stb, input_b_stb  out  1  operand strobes to the adder.
- input_a_ack, input_b_ack  in  1  operand acknowledges from the adder.
- output_z  in  32  sum from the adder.
- output_z_stb  in  1  sum valid from the adder.
- output_z_ack  out  1  sum acknowledge to the adder.
- rsp_valid  out  1  result available upstream.
- rsp_ready  in  1  upstream accepts the result.
- rsp_z  out  32  returned sum.
- rsp_err  out  1  result produced by timeout, not by the adder.
- done_count  out  CNT_W  number of successful results accepted upstream; wraps.

## Operation
- States: IDLE, SEND_A, SEND_B, WAIT_Z, RESP.
- All outputs are decoded from the state register or taken from registers; there is no combinational path from input to output.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_a and req_b into a_reg and b_reg, clear the timer, and go to SEND_A.
- SEND_A:
  - input_a_stb=1, input_a=a_reg.
  - Transfer happens on the edge where input_a_stb and input_a_ack are both 1; then go to SEND_B and clear the timer.
- SEND_B:
  - Same as SEND_A, using the b_reg/input_b_* signals.
  - On transfer, go to WAIT_Z.
- WAIT_Z:
  - output_z_ack=1.
  - On the edge where output_z_stb=1: capture output_z into rsp_z, set rsp_err=0, and go to RESP.
- RESP:
  - rsp_valid=1.
  - On rsp_ready: go to IDLE.
  - Increment done_count only if rsp_err=0.
- Timeout:
  - In SEND_A, SEND_B or WAIT_Z, the timer counts the cycles spent in the state.
  - When the timer reaches TIMEOUT_CYCLES-1 with no transfer, go to RESP with rsp_z=32'h7FC00000 (quiet NaN) and rsp_err=1.
- input_a and input_b hold their last value outside the send states.
- Strobes are 0 outside their own state.
- No arithmetic is done on operand or result data; it passes through bit-exact.

## Timing
- Reset values: req_ready=0 while rst=0, and 1 in the first cycle after release. All other outputs reset to 0, including input_a, input_b, rsp_z and done_count. Reset state is IDLE.
- Reset in mid-operation: strobes, output_z_ack and rsp_valid drop immediately (asynchronously). The in-flight request is lost and is not counted.
- Minimum latency, with acks already high and output_z_stb high on arrival in WAIT_Z:
  - request accepted at edge 0;
  - A transferred at edge 1;
  - B transferred at edge 2;
  - Z captured at edge 3;
  - rsp_valid=1 in cycle 4.
- One request in flight at a time. req_ready=0 from the accept edge until the cycle after RESP exits, so there is no same-cycle turnaround.
- If a transfer and a timer expiry fall on the same edge, the transfer wins and rsp_err=0.
- rsp_z and rsp_err hold steady while rsp_valid=1 and rsp_ready=0.
- done_count wraps from 2^CNT_W-1 to 0.

## Structure
- Shared package fpu_pkg: the state encoding, the FP32_QNAN constant (32'h7FC00000) and the FP32 width constant, shared with the adder and issue logic.
- One sub-module, fpu_hs_timer. It holds a clear-able cycle counter sized with $clog2(TIMEOUT_CYCLES) and asserts expire at TIMEOUT_CYCLES-1.

## Test plan
- Basic add: req_a=32'h417C0000 (15.75), req_b=32'h40E80000 (7.25), with a model adder.
  - Expect rsp_z=32'h41B80000 (23.0), rsp_err=0, done_count=1.
  - Expect input_b_stb to rise only after the A transfer.
- Ack delay: hold input_a_ack low for 5 cycles and input_b_ack low for 3 cycles.
  - Expect each strobe held steady, operands stable, and a single transfer each.
  - Expect rsp_valid=1 exactly 1 cycle after the Z transfer.
- Backpressure: hold rsp_ready low for 10 cycles.
  - Expect rsp_valid, rsp_z and req_ready=0 to stay constant.
  - Expect a new req_valid presented during this time to be accepted only after release.
- Timeout: output_z_stb never asserts, TIMEOUT_CYCLES=8.
  - Expect RESP after 8 cycles in WAIT_Z with rsp_z=32'h7FC00000, rsp_err=1, and done_count unchanged.
- Tie: input_b_ack rises on the expiry edge.
  - Expect a normal transfer to WAIT_Z, with no error.
- Reset mid-op: pull rst low while in SEND_B.
  - Expect all outputs 0 immediately.
  - After release, expect IDLE with req_ready=1 and the next add to complete correctly.
